// File: rtl/keypad_pkg.sv
// Shared types, defaults and row-decoding helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int SCAN_DIV_W_DEF = 15;
    localparam int DEBOUNCE_N_DEF = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Ghosting and multi-key presses show up as more than one low row.
    function automatic logic single_low(input logic [3:0] rows);
        return ($countones(~rows) == 1);
    endfunction

    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// Free-running prescaler: one-clk tick each time the counter wraps to zero.
module kp_tick_gen #(
    parameter int WIDTH = 15
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        tick_d = (cnt_q == {WIDTH{1'b1}});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner with debounce, single-key acceptance and an
// 8-digit entry shift register. state_dbg mirrors the scan FSM state.
module keypad4x4_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W = SCAN_DIV_W_DEF,
    parameter int DEBOUNCE_N = DEBOUNCE_N_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    input  logic        clr_i,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] entry_data,
    output kp_state_e   state_dbg
);

    localparam int DB_W = $clog2(DEBOUNCE_N + 1);

    logic            tick;
    logic [3:0]      sync1_q, rows_s_q;
    kp_state_e       state_q, state_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_o_q, col_o_d;
    logic [3:0]      pat_q, pat_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d, db_inc;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_held_q, key_held_d;
    logic [31:0]     entry_q, entry_d;

    kp_tick_gen #(
        .WIDTH (SCAN_DIV_W)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        pat_d       = pat_q;
        db_cnt_d    = db_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        db_inc      = db_cnt_q + DB_W'(1);

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (single_low(rows_s_q)) begin
                        pat_d    = rows_s_q;
                        db_cnt_d = DB_W'(1);
                        state_d  = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s_q == pat_q) begin
                        db_cnt_d = db_inc;
                        if (db_inc >= DB_W'(DEBOUNCE_N)) begin
                            state_d     = ST_PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = {low_row_idx(pat_q), col_idx_q};
                            key_held_d  = 1'b1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (rows_s_q == 4'hF) begin
                        state_d  = ST_RELEASE;
                        db_cnt_d = DB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (rows_s_q == 4'hF) begin
                        db_cnt_d = db_inc;
                        if (db_inc >= DB_W'(DEBOUNCE_N)) begin
                            state_d    = ST_SCAN;
                            col_idx_d  = col_idx_q + 2'd1;
                            key_held_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        col_o_d = ~(4'b0001 << col_idx_d);

        // A clear in the same clk as a pulse drops the new code as well.
        entry_d = entry_q;
        if (clr_i) begin
            entry_d = '0;
        end else if (key_valid_q) begin
            entry_d = {entry_q[27:0], key_code_q};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= 4'hF;
            rows_s_q    <= 4'hF;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            col_o_q     <= 4'b1110;
            pat_q       <= 4'hF;
            db_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            entry_q     <= '0;
        end else begin
            sync1_q     <= row_i;
            rows_s_q    <= sync1_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_o_q     <= col_o_d;
            pat_q       <= pat_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    assign col_o      = col_o_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_held   = key_held_q;
    assign entry_data = entry_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Self-checking bench for keypad4x4_scan with a column-aware keypad model.
module tb_keypad4x4_scan;
    import keypad_pkg::*;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int TICK = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr_i;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] entry_data;
    kp_state_e   state_dbg;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [31:0] exp_entry;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulse_cnt = 0;

    keypad4x4_scan #(
        .SCAN_DIV_W (W),
        .DEBOUNCE_N (N)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .row_i      (row_i),
        .col_o      (col_o),
        .clr_i      (clr_i),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held),
        .entry_data (entry_data),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp;
        if (rstn && key_valid) begin
            pulse_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: key_code=%h, no press pending", key_code);
            end else begin
                exp = exp_q.pop_front();
                if (key_code !== exp) begin
                    n_fail++;
                    $display("FAIL key_code: got %h, expected %h", key_code, exp);
                end
                exp_entry = {exp_entry[27:0], exp};
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held_low(input string name);
        int t;
        t = 0;
        while (key_held && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (key_held) begin
            n_fail++;
            $display("FAIL %s_release_timeout: key_held=%b, expected 0", name, key_held);
        end
    endtask

    task automatic wait_state(input kp_state_e st, input string name);
        int t;
        t = 0;
        while (state_dbg != st && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (state_dbg != st) begin
            n_fail++;
            $display("FAIL %s_state_timeout: state=%0d, expected %0d", name, state_dbg, st);
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_cols[4];
        logic [3:0] prev;
        int         t;
        exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rstn = 1'b0;
        clr_i = 1'b0;
        pressed = '0;
        exp_entry = '0;
        wait_clks(3);
        n_checks++;
        if (col_o !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            key_held !== 1'b0 || entry_data !== 32'h0 || state_dbg !== ST_SCAN) begin
            n_fail++;
            $display("FAIL reset_values: col_o=%b kv=%b code=%h held=%b entry=%h st=%0d, expected 1110 0 0 0 0 0",
                     col_o, key_valid, key_code, key_held, entry_data, state_dbg);
        end
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            prev = col_o;
            t = 0;
            while (col_o === prev && t < 40) begin
                @(negedge clk);
                t++;
            end
            n_checks++;
            if (col_o !== exp_cols[k] || (k > 0 && t != TICK)) begin
                n_fail++;
                $display("FAIL col_step%0d: col_o=%b after %0d clk, expected %b after %0d clk",
                         k, col_o, t, exp_cols[k], TICK);
            end
        end
        n_checks++;
        if (pulse_cnt != 0 || entry_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: pulses=%0d entry=%h, expected 0 and 0", pulse_cnt, entry_data);
        end
    endtask

    task automatic test_single_key;
        int p0;
        int t;
        p0 = pulse_cnt;
        exp_q.push_back(4'h6);
        pressed[1*4+2] = 1'b1;
        wait_clks(12 * TICK);
        n_checks++;
        if (pulse_cnt - p0 != 1 || key_held !== 1'b1 || key_code !== 4'h6) begin
            n_fail++;
            $display("FAIL single_press: pulses=%0d held=%b code=%h, expected 1 1 6",
                     pulse_cnt - p0, key_held, key_code);
        end
        n_checks++;
        if (entry_data !== 32'h00000006) begin
            n_fail++;
            $display("FAIL single_entry: entry=%h, expected 00000006", entry_data);
        end
        pressed = '0;
        t = 0;
        while (key_held && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (key_held !== 1'b0 || t < 3 * TICK || t > 4 * TICK + 4) begin
            n_fail++;
            $display("FAIL single_release: held=%b dropped after %0d clk, expected 0 within %0d..%0d clk",
                     key_held, t, 3 * TICK, 4 * TICK + 4);
        end
        n_checks++;
        if (pulse_cnt - p0 != 1) begin
            n_fail++;
            $display("FAIL single_count: pulses=%0d, expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_sequence;
        logic [3:0] code;
        for (int k = 1; k <= 9; k++) begin
            code = 4'(k);
            exp_q.push_back(code);
            pressed[k] = 1'b1;
            wait_clks(10 * TICK);
            n_checks++;
            if (exp_q.size() != 0 || key_code !== code) begin
                n_fail++;
                $display("FAIL seq_key%0d: pending=%0d code=%h, expected 0 pending code %h",
                         k, exp_q.size(), key_code, code);
            end
            pressed = '0;
            wait_held_low("seq");
            wait_clks(2 * TICK);
        end
        n_checks++;
        if (entry_data !== 32'h23456789 || entry_data !== exp_entry) begin
            n_fail++;
            $display("FAIL seq_entry: entry=%h, expected 23456789 (model %h)", entry_data, exp_entry);
        end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulse_cnt;
        pressed[1*4+2] = 1'b1;
        wait_state(ST_DEBOUNCE, "bounce");
        wait_clks(TICK + 2);
        pressed = '0;
        wait_state(ST_SCAN, "bounce_back");
        n_checks++;
        if (col_o !== 4'b0111 || pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL bounce: col_o=%b pulses=%0d, expected 0111 and 0", col_o, pulse_cnt - p0);
        end
        wait_clks(6 * TICK);
        n_checks++;
        if (pulse_cnt != p0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_after: pulses=%0d held=%b, expected 0 0", pulse_cnt - p0, key_held);
        end
    endtask

    task automatic test_ghost;
        int          p0;
        logic [31:0] e0;
        p0 = pulse_cnt;
        e0 = exp_entry;
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        wait_clks(12 * TICK);
        n_checks++;
        if (pulse_cnt != p0 || key_held !== 1'b0 || entry_data !== e0) begin
            n_fail++;
            $display("FAIL ghost: pulses=%0d held=%b entry=%h, expected 0 0 %h",
                     pulse_cnt - p0, key_held, entry_data, e0);
        end
        pressed = '0;
        wait_clks(2 * TICK);
    endtask

    task automatic test_clear_coincide;
        int   t;
        logic seen;
        exp_q.push_back(4'hB);
        pressed[2*4+3] = 1'b1;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 300) begin
            @(posedge clk);
            #1;
            seen = key_valid;
            t++;
        end
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        n_checks++;
        if (!seen || entry_data !== 32'h0 || key_code !== 4'hB) begin
            n_fail++;
            $display("FAIL clear_coincide: pulse_seen=%b entry=%h code=%h, expected 1 00000000 b",
                     seen, entry_data, key_code);
        end
        exp_entry = '0;
        pressed = '0;
        wait_held_low("clear");
        wait_clks(TICK);
    endtask

    task automatic test_reset_mid_debounce;
        int p0;
        p0 = pulse_cnt;
        pressed[3*4+0] = 1'b1;
        wait_state(ST_DEBOUNCE, "rst_mid");
        wait_clks(TICK + 5);
        rstn = 1'b0;
        #2;
        n_checks++;
        if (state_dbg !== ST_SCAN || col_o !== 4'b1110 || key_valid !== 1'b0 || entry_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_debounce: st=%0d col_o=%b kv=%b entry=%h, expected 0 1110 0 0",
                     state_dbg, col_o, key_valid, entry_data);
        end
        pressed = '0;
        exp_entry = '0;
        wait_clks(3);
        rstn = 1'b1;
        wait_clks(12 * TICK);
        n_checks++;
        if (pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: pulses=%0d, expected 0", pulse_cnt - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_ghost();
        test_clear_coincide();
        test_reset_mid_debounce();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d presses without pulse, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
